ppi_bus_master: RTL and testbench



---
 rtl/ppi_bus_master.sv | 129 ++++++++++++
 tb/tb_ppi_bus_master.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ppi_bus_master.sv
// Bus initiator for an 8255-style PPI. It turns each accepted valid/ready request
// into a bus cycle made of a setup phase, a strobe phase and a hold phase, with every bus output registered.
module ppi_bus_master #(
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 2,
    parameter int HOLD_CYC   = 1
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       REQ_VALID,
    output logic       REQ_READY,
    input  logic       REQ_WRITE,
    input  logic [1:0] REQ_ADDR,
    input  logic [7:0] REQ_DATA,
    output logic       DONE,
    output logic [7:0] RSP_DATA,
    output logic       BUSY,
    output logic       CS_,
    output logic       RD_,
    output logic       WR_,
    output logic [1:0] A,
    inout  wire  [7:0] PORTD_IO
);

    // A phase length of zero is treated as one cycle.
    localparam int SETUP_EFF  = (SETUP_CYC  < 1) ? 1 : SETUP_CYC;
    localparam int STROBE_EFF = (STROBE_CYC < 1) ? 1 : STROBE_CYC;
    localparam int HOLD_EFF   = (HOLD_CYC   < 1) ? 1 : HOLD_CYC;

    localparam logic [7:0] SETUP_LD  = 8'(SETUP_EFF  - 1);
    localparam logic [7:0] STROBE_LD = 8'(STROBE_EFF - 1);
    localparam logic [7:0] HOLD_LD   = 8'(HOLD_EFF   - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } state_t;

    state_t     state_reg;
    logic [7:0] cnt_reg;
    logic       write_reg;
    logic [7:0] data_reg;
    logic       drive_reg;
    logic       cs_n_reg;
    logic       rd_n_reg;
    logic       wr_n_reg;
    logic [1:0] addr_reg;
    logic       done_reg;
    logic [7:0] rsp_reg;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_reg <= IDLE;
            cnt_reg   <= 8'd0;
            write_reg <= 1'b0;
            data_reg  <= 8'd0;
            drive_reg <= 1'b0;
            cs_n_reg  <= 1'b1;
            rd_n_reg  <= 1'b1;
            wr_n_reg  <= 1'b1;
            addr_reg  <= 2'd0;
            done_reg  <= 1'b0;
            rsp_reg   <= 8'd0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (REQ_VALID) begin
                        state_reg <= SETUP;
                        cnt_reg   <= SETUP_LD;
                        write_reg <= REQ_WRITE;
                        data_reg  <= REQ_DATA;
                        drive_reg <= REQ_WRITE;
                        addr_reg  <= REQ_ADDR;
                        cs_n_reg  <= 1'b0;
                    end
                end
                SETUP: begin
                    if (cnt_reg == 8'd0) begin
                        state_reg <= STROBE;
                        cnt_reg   <= STROBE_LD;
                        wr_n_reg  <= ~write_reg;
                        rd_n_reg  <= write_reg;
                    end else begin
                        cnt_reg <= cnt_reg - 8'd1;
                    end
                end
                STROBE: begin
                    if (cnt_reg == 8'd0) begin
                        state_reg <= HOLD;
                        cnt_reg   <= HOLD_LD;
                        wr_n_reg  <= 1'b1;
                        rd_n_reg  <= 1'b1;
                        // The bus is sampled on the edge that ends the strobe, while RD_ is still low.
                        if (!write_reg) begin
                            rsp_reg <= PORTD_IO;
                        end
                    end else begin
                        cnt_reg <= cnt_reg - 8'd1;
                    end
                end
                HOLD: begin
                    if (cnt_reg == 8'd0) begin
                        state_reg <= IDLE;
                        cs_n_reg  <= 1'b1;
                        drive_reg <= 1'b0;
                        done_reg  <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg - 8'd1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign REQ_READY = (state_reg == IDLE) && !RESET;
    assign BUSY      = (state_reg != IDLE);
    assign DONE      = done_reg;
    assign RSP_DATA  = rsp_reg;
    assign CS_       = cs_n_reg;
    assign RD_       = rd_n_reg;
    assign WR_       = wr_n_reg;
    assign A         = addr_reg;
    assign PORTD_IO  = drive_reg ? data_reg : 8'hzz;

endmodule

// File: tb/tb_ppi_bus_master.sv
// Bench for ppi_bus_master. It runs a default-timing instance against a small PPI register model
// and a second instance with stretched phases; read responses are checked through a scoreboard queue.
module tb_ppi_bus_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       req_valid, req_write, req_ready, done, busy, cs_n, rd_n, wr_n;
    logic [1:0] req_addr, a;
    logic [7:0] req_data, rsp_data;
    tri0  [7:0] portd;

    logic       req_valid2, req_write2, req_ready2, done2, busy2, cs_n2, rd_n2, wr_n2;
    logic [1:0] req_addr2, a2;
    logic [7:0] req_data2, rsp_data2;
    tri0  [7:0] portd2;

    ppi_bus_master dut (
        .CLK(clk), .RESET(rst), .REQ_VALID(req_valid), .REQ_READY(req_ready),
        .REQ_WRITE(req_write), .REQ_ADDR(req_addr), .REQ_DATA(req_data),
        .DONE(done), .RSP_DATA(rsp_data), .BUSY(busy), .CS_(cs_n), .RD_(rd_n),
        .WR_(wr_n), .A(a), .PORTD_IO(portd)
    );

    ppi_bus_master #(.SETUP_CYC(3), .STROBE_CYC(4), .HOLD_CYC(2)) dut2 (
        .CLK(clk), .RESET(rst), .REQ_VALID(req_valid2), .REQ_READY(req_ready2),
        .REQ_WRITE(req_write2), .REQ_ADDR(req_addr2), .REQ_DATA(req_data2),
        .DONE(done2), .RSP_DATA(rsp_data2), .BUSY(busy2), .CS_(cs_n2), .RD_(rd_n2),
        .WR_(wr_n2), .A(a2), .PORTD_IO(portd2)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // PPI model: four registers; port A reads back 0x5A when the control word selects port A as input.
    logic [7:0] ppi_reg [4];
    logic [7:0] ppi_rd_val;

    always_comb begin
        ppi_rd_val = ppi_reg[a];
        if (a == 2'd0 && ppi_reg[3][4]) ppi_rd_val = 8'h5A;
    end

    assign portd = (!cs_n && !rd_n) ? ppi_rd_val : 8'hzz;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) ppi_reg[i] <= 8'd0;
        end else if (!cs_n && !wr_n) begin
            ppi_reg[a] <= portd;
        end
    end

    // Scoreboard: the expected RSP_DATA is pushed at acceptance and popped when DONE pulses.
    logic [7:0] sb_q [$];
    logic [7:0] sb_exp;
    logic [7:0] shadow [4];
    logic [7:0] exp_rsp;

    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb_q.size() == 0) begin
                check("done_unexpected", 32'(done), 32'(0));
            end else begin
                sb_exp = sb_q.pop_front();
                check("rsp_data", 32'(rsp_data), 32'(sb_exp));
                $display("[TB] txn done: rsp_data=0x%02h expected 0x%02h", rsp_data, sb_exp);
            end
        end
    end

    // Called on a negedge; returns on the negedge of the DONE cycle.
    task automatic txn(input logic w, input logic [1:0] ad, input logic [7:0] d,
                       input logic hold, input logic nw, input logic [1:0] nad, input logic [7:0] nd);
        logic strobe, last;
        req_valid = 1'b1;
        req_write = w;
        req_addr  = ad;
        req_data  = d;
        for (int k = 0; k < 40 && !req_ready; k++) @(negedge clk);
        if (!req_ready) begin
            check("accept_timeout", 32'(req_ready), 32'(1));
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        if (w) shadow[ad] = d;
        else exp_rsp = (ad == 2'd0 && shadow[3][4]) ? 8'h5A : shadow[ad];
        sb_q.push_back(exp_rsp);
        $display("[TB] txn accepted: %s addr=%0d data=0x%02h", w ? "write" : "read", ad, w ? d : exp_rsp);
        #1;
        if (hold) begin
            req_write = nw;
            req_addr  = nad;
            req_data  = nd;
        end else begin
            req_valid = 1'b0;
            req_write = ~w;
            req_addr  = ~ad;
            req_data  = ~d;
        end
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            strobe = (k >= 2 && k <= 3);
            last   = (k == 5);
            check("cs", 32'(cs_n), 32'(last));
            if (!last) check("addr", 32'(a), 32'(ad));
            check("rd", 32'(rd_n), 32'(!(strobe && !w)));
            check("wr", 32'(wr_n), 32'(!(strobe && w)));
            check("bus", 32'(portd), 32'((w && !last) ? d : (!w && strobe) ? exp_rsp : 8'h00));
            check("done", 32'(done), 32'(last));
            check("busy", 32'(busy), 32'(!last));
            check("ready", 32'(req_ready), 32'(last));
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int wr_low;
        for (int i = 0; i < 4; i++) shadow[i] = 8'd0;
        exp_rsp    = 8'd0;
        rst        = 1'b1;
        req_valid  = 1'b1;
        req_write  = 1'b1;
        req_addr   = 2'd3;
        req_data   = 8'h80;
        req_valid2 = 1'b0;
        req_write2 = 1'b0;
        req_addr2  = 2'd0;
        req_data2  = 8'd0;

        // Reset held with a request pending.
        repeat (2) begin
            @(negedge clk);
            check("rst_cs", 32'(cs_n), 32'(1));
            check("rst_rd", 32'(rd_n), 32'(1));
            check("rst_wr", 32'(wr_n), 32'(1));
            check("rst_bus", 32'(portd), 32'(0));
            check("rst_done", 32'(done), 32'(0));
            check("rst_rsp", 32'(rsp_data), 32'(0));
            check("rst_busy", 32'(busy), 32'(0));
        end
        rst       = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        check("post_rst_busy", 32'(busy), 32'(0));
        check("post_rst_cs", 32'(cs_n), 32'(1));
        check("post_rst_ready", 32'(req_ready), 32'(1));

        // Writes to the control register, then a read of port A in input mode.
        txn(1'b1, 2'd3, 8'h80, 1'b0, 1'b0, 2'd0, 8'h00);
        check("ppi_ctrl", 32'(ppi_reg[3]), 32'(8'h80));
        txn(1'b1, 2'd3, 8'h90, 1'b0, 1'b0, 2'd0, 8'h00);
        check("ppi_ctrl2", 32'(ppi_reg[3]), 32'(8'h90));
        txn(1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 2'd0, 8'h00);

        // Back-to-back: a write to port B, then a read of port B held pending while busy.
        txn(1'b1, 2'd1, 8'h3C, 1'b1, 1'b0, 2'd1, 8'h00);
        txn(1'b0, 2'd1, 8'h00, 1'b0, 1'b0, 2'd0, 8'h00);

        // Reset during the second strobe cycle of a write.
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 2'd2;
        req_data  = 8'hFF;
        check("abort_ready", 32'(req_ready), 32'(1));
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("abort_setup_bus", 32'(portd), 32'(8'hFF));
        @(negedge clk);
        check("abort_strobe1", 32'(wr_n), 32'(0));
        @(negedge clk);
        check("abort_strobe2", 32'(wr_n), 32'(0));
        rst = 1'b1;
        @(negedge clk);
        check("abort_wr", 32'(wr_n), 32'(1));
        check("abort_cs", 32'(cs_n), 32'(1));
        check("abort_bus", 32'(portd), 32'(0));
        check("abort_busy", 32'(busy), 32'(0));
        check("abort_done", 32'(done), 32'(0));
        check("abort_rsp", 32'(rsp_data), 32'(0));
        $display("[TB] txn aborted by reset: write addr=2 data=0xff");
        rst     = 1'b0;
        exp_rsp = 8'd0;
        for (int i = 0; i < 4; i++) shadow[i] = 8'd0;
        repeat (6) begin
            @(negedge clk);
            check("abort_no_done", 32'(done), 32'(0));
        end

        // Stretched timing: inputs scrambled every cycle after acceptance.
        req_valid2 = 1'b1;
        req_write2 = 1'b1;
        req_addr2  = 2'd2;
        req_data2  = 8'hC3;
        check("t6_ready0", 32'(req_ready2), 32'(1));
        @(posedge clk);
        wr_low = 0;
        for (int k = 1; k <= 10; k++) begin
            #1;
            req_data2  = 8'($urandom);
            req_addr2  = 2'($urandom);
            req_write2 = 1'($urandom);
            @(negedge clk);
            if (!wr_n2) wr_low++;
            check("t6_cs", 32'(cs_n2), 32'(k == 10));
            if (k < 10) check("t6_addr", 32'(a2), 32'(2));
            check("t6_wr", 32'(wr_n2), 32'(!(k >= 4 && k <= 7)));
            check("t6_rd", 32'(rd_n2), 32'(1));
            check("t6_bus", 32'(portd2), 32'((k < 10) ? 8'hC3 : 8'h00));
            check("t6_done", 32'(done2), 32'(k == 10));
            check("t6_ready", 32'(req_ready2), 32'(k == 10));
            if (k == 10) req_valid2 = 1'b0;
            @(posedge clk);
        end
        check("t6_strobe_width", 32'(wr_low), 32'(4));
        $display("[TB] txn done (stretched): write addr=2 data=0xc3 strobe=%0d", wr_low);

        repeat (3) @(negedge clk);
        check("t6_idle_busy", 32'(busy2), 32'(0));
        check("sb_empty", 32'(sb_q.size()), 32'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
